rr_timeout_arbiter: RTL and testbench

//  N-input round-robin arbiter for the router output port with per-input hold timers.

---
 rtl/arbiter_pkg.sv | 27 ++
 rtl/hold_timer.sv | 46 ++++
 rtl/rr_timeout_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_timeout_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared constants, flit type encoding and round-robin helper for the
// router output-port arbiter.
package arbiter_pkg;

    localparam int NPORTS_DEFAULT = 5;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    localparam int HEADER_ID = 1;

    typedef enum logic [2:0] {
        FLIT_IDLE = 3'd0,
        FLIT_HEAD = 3'd1,
        FLIT_BODY = 3'd2,
        FLIT_TAIL = 3'd3
    } flit_type_e;

    // Index that follows idx in a ring of n ports.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Per-port hold timer: latches the packet budget from header flits and
// counts granted cycles; flags expiry once the budget has been consumed.
module hold_timer #(
    parameter int LEN_W      = 12,
    parameter int FLIT_ID_W  = 3,
    parameter int HEADER_ID  = arbiter_pkg::HEADER_ID,
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_ID_W-1:0] flit_id,
    input  logic [LEN_W-1:0]     length,
    input  logic                 run,
    input  logic                 clear,
    output logic                 expired
);

    logic [LEN_W-1:0] budget_q;
    logic [LEN_W-1:0] budget_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    always_comb begin
        budget_d = (flit_id == FLIT_ID_W'(HEADER_ID)) ? length : budget_q;
        cnt_d    = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            budget_q <= '0;
            cnt_q    <= '0;
        end else begin
            budget_q <= budget_d;
            cnt_q    <= cnt_d;
        end
    end

    // A zero budget means unlimited hold; >= lets a shrunken budget expire at once.
    assign expired = TIMEOUT_EN && (budget_q != '0) && (cnt_q >= budget_q - LEN_W'(1));

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-port arbiter with per-input hold budgets; registered
// one-hot grant plus valid flag and binary index.
module rr_timeout_arbiter #(
    parameter int  NPORTS     = arbiter_pkg::NPORTS_DEFAULT,
    parameter int  LEN_W      = 12,
    parameter int  FLIT_ID_W  = 3,
    parameter int  HEADER_ID  = arbiter_pkg::HEADER_ID,
    parameter bit  TIMEOUT_EN = 1'b1,
    localparam int IDX_W      = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORTS-1:0]           req,
    input  logic [NPORTS*FLIT_ID_W-1:0] flit_id,
    input  logic [NPORTS*LEN_W-1:0]     length,
    output logic [NPORTS-1:0]           grant,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx
);
    import arbiter_pkg::*;

    logic [NPORTS-1:0] grant_q;
    logic [NPORTS-1:0] grant_d;
    logic              grant_valid_q;
    logic              grant_valid_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;

    logic [NPORTS-1:0] expired;
    logic [NPORTS-1:0] run;
    logic [NPORTS-1:0] eligible;
    logic [IDX_W-1:0]  cur_idx;
    logic [IDX_W-1:0]  base_idx;
    logic              onehot_ok;
    logic              holding;
    logic              keep;
    logic              found;
    int                start;
    int                off;
    int                best_off;
    int                pick;

    always_comb begin
        onehot_ok = ((grant_q & (grant_q - NPORTS'(1))) == '0);
        cur_idx   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) cur_idx = IDX_W'(i);
        end
        holding = onehot_ok && (|grant_q);
        keep    = holding && req[cur_idx] && !expired[cur_idx];

        // While holding, the current owner is excluded so an expired port
        // with req still high must pass through one idle cycle.
        base_idx = holding ? cur_idx : ptr_q;
        eligible = req;
        if (holding) eligible[cur_idx] = 1'b0;

        start    = rr_next(int'(base_idx), NPORTS);
        found    = 1'b0;
        pick     = 0;
        best_off = NPORTS;
        off      = 0;
        for (int i = 0; i < NPORTS; i++) begin
            off = (i >= start) ? i - start : i + NPORTS - start;
            if (eligible[i] && off < best_off) begin
                best_off = off;
                pick     = i;
                found    = 1'b1;
            end
        end

        grant_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (onehot_ok) grant_d[i] = keep ? grant_q[i] : (found && pick == i);
        end

        ptr_d = holding ? cur_idx : ptr_q;

        grant_valid_d = |grant_d;
        idx_d         = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_d[i]) idx_d = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            idx_q         <= '0;
            ptr_q         <= IDX_W'(NPORTS - 1);
        end else begin
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
        end
    end

    assign run = grant_q & grant_d;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_timer
            hold_timer #(
                .LEN_W      (LEN_W),
                .FLIT_ID_W  (FLIT_ID_W),
                .HEADER_ID  (HEADER_ID),
                .TIMEOUT_EN (TIMEOUT_EN)
            ) u_timer (
                .clk     (clk),
                .rst     (rst),
                .flit_id (flit_id[gi*FLIT_ID_W +: FLIT_ID_W]),
                .length  (length[gi*LEN_W +: LEN_W]),
                .run     (run[gi]),
                .clear   (~run[gi]),
                .expired (expired[gi])
            );
        end
    endgenerate

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Scenario bench for rr_timeout_arbiter: expected grants are queued as
// stimulus is driven and compared after each rising edge.
module tb_rr_timeout_arbiter;
    import arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  req,     req2;
    logic [14:0] flit_id, flit_id2;
    logic [59:0] length,  length2;
    logic [4:0]  grant,   grant2;
    logic        gv,      gv2;
    logic [2:0]  gidx,    gidx2;

    logic [4:0]  exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    rr_timeout_arbiter #(.NPORTS(5), .LEN_W(12), .FLIT_ID_W(3), .HEADER_ID(1), .TIMEOUT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
        .grant(grant), .grant_valid(gv), .grant_idx(gidx)
    );

    rr_timeout_arbiter #(.NPORTS(5), .LEN_W(12), .FLIT_ID_W(3), .HEADER_ID(1), .TIMEOUT_EN(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .req(req2), .flit_id(flit_id2), .length(length2),
        .grant(grant2), .grant_valid(gv2), .grant_idx(gidx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] idx_of(input logic [4:0] g);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic drive(input bit u2, input logic [4:0] r, input logic [4:0] e);
        @(negedge clk);
        if (u2) req2 = r; else req = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_header(input bit u2, input int port, input int len);
        if (u2) begin
            flit_id2[port*3 +: 3] = FLIT_HEAD;
            length2[port*12 +: 12] = 12'(len);
        end else begin
            flit_id[port*3 +: 3] = FLIT_HEAD;
            length[port*12 +: 12] = 12'(len);
        end
    endtask

    task automatic clear_headers();
        flit_id  = '0;
        flit_id2 = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        req2 = '0;
        clear_headers();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        #3;
        n_tests++;
        if (grant !== 5'b0 || gv !== 1'b0 || gidx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b valid=%b idx=%0d required 00000/0/0", grant, gv, gidx);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 5'b00000, 5'b00000);
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e || gv !== (|e) || gidx !== idx_of(e)) begin
                n_fail++;
                $display("FAIL reset_idle step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant, gv, gidx, e, |e, idx_of(e));
            end
            $display("[TB] reset_idle step %0d req=00000 grant=%b exp=%b", s, grant, e);
        end
    endtask

    task automatic test_unlimited();
        logic [4:0] r, e;
        for (int s = 0; s < 13; s++) begin
            if (s < 10)       begin r = 5'b11111; e = 5'b00001; end
            else if (s < 12)  begin r = 5'b11110; e = 5'b00010; end
            else              begin r = 5'b00000; e = 5'b00000; end
            drive(1'b0, r, e);
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e || gv !== (|e) || gidx !== idx_of(e)) begin
                n_fail++;
                $display("FAIL unlimited step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant, gv, gidx, e, |e, idx_of(e));
            end
            $display("[TB] unlimited step %0d req=%b grant=%b exp=%b", s, r, grant, e);
        end
    endtask

    task automatic test_budget_repeat();
        logic [4:0] e;
        logic [4:0] tbl [9];
        tbl = '{5'b00100, 5'b00100, 5'b00100, 5'b00000,
                5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
        set_header(1'b0, PORT_E, 3);
        drive(1'b0, 5'b00000, 5'b00000);
        void'(exp_q.pop_front());
        clear_headers();
        for (int s = 0; s < 9; s++) begin
            drive(1'b0, (s < 8) ? 5'b00100 : 5'b00000, tbl[s]);
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e || gv !== (|e) || gidx !== idx_of(e)) begin
                n_fail++;
                $display("FAIL budget_repeat step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant, gv, gidx, e, |e, idx_of(e));
            end
            $display("[TB] budget_repeat step %0d grant=%b exp=%b", s, grant, e);
        end
    endtask

    task automatic test_rotation();
        logic [4:0] e;
        logic [4:0] tbl [13];
        tbl = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100,
                5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b00001, 5'b00001, 5'b00000};
        apply_reset();
        for (int p = 0; p < 5; p++) set_header(1'b0, p, 2);
        drive(1'b0, 5'b00000, 5'b00000);
        void'(exp_q.pop_front());
        clear_headers();
        for (int s = 0; s < 13; s++) begin
            drive(1'b0, (s < 12) ? 5'b11111 : 5'b00000, tbl[s]);
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e || gv !== (|e) || gidx !== idx_of(e)) begin
                n_fail++;
                $display("FAIL rotation step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant, gv, gidx, e, |e, idx_of(e));
            end
            $display("[TB] rotation step %0d grant=%b exp=%b", s, grant, e);
        end
    endtask

    task automatic test_shrink();
        logic [4:0] r, e;
        apply_reset();
        set_header(1'b0, PORT_N, 10);
        drive(1'b0, 5'b00000, 5'b00000);
        void'(exp_q.pop_front());
        clear_headers();
        for (int s = 0; s < 12; s++) begin
            if (s == 7) set_header(1'b0, PORT_N, 4);
            if (s < 8)        begin r = 5'b01010; e = 5'b00010; end
            else if (s == 8)  begin r = 5'b01010; e = 5'b01000; end
            else if (s < 11)  begin r = 5'b01000; e = 5'b01000; end
            else              begin r = 5'b00000; e = 5'b00000; end
            drive(1'b0, r, e);
            clear_headers();
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e || gv !== (|e) || gidx !== idx_of(e)) begin
                n_fail++;
                $display("FAIL shrink step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant, gv, gidx, e, |e, idx_of(e));
            end
            $display("[TB] shrink step %0d req=%b grant=%b exp=%b", s, r, grant, e);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] e;
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            drive(1'b0, 5'b10000, 5'b10000);
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e) begin
                n_fail++;
                $display("FAIL midreset_hold step %0d: grant=%b required %b", s, grant, e);
            end
            $display("[TB] midreset_hold step %0d grant=%b exp=%b", s, grant, e);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (grant !== 5'b0 || gv !== 1'b0 || gidx !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: grant=%b valid=%b idx=%0d required 00000/0/0", grant, gv, gidx);
        end
        $display("[TB] async_reset grant=%b exp=00000", grant);
        req = 5'b10001;
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(5'b00001);
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) drive(1'b0, 5'b10001, 5'b00001);
            if (s == 2) drive(1'b0, 5'b00000, 5'b00000);
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e || gv !== (|e) || gidx !== idx_of(e)) begin
                n_fail++;
                $display("FAIL after_reset step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant, gv, gidx, e, |e, idx_of(e));
            end
            $display("[TB] after_reset step %0d grant=%b exp=%b", s, grant, e);
        end
    endtask

    task automatic test_no_timeout();
        logic [4:0] e;
        set_header(1'b1, PORT_L, 2);
        drive(1'b1, 5'b00000, 5'b00000);
        void'(exp_q.pop_front());
        clear_headers();
        for (int s = 0; s < 21; s++) begin
            drive(1'b1, (s < 20) ? 5'b00001 : 5'b00000, (s < 20) ? 5'b00001 : 5'b00000);
            e = exp_q.pop_front();
            n_tests++;
            if (grant2 !== e || gv2 !== (|e) || gidx2 !== idx_of(e)) begin
                n_fail++;
                $display("FAIL no_timeout step %0d: grant=%b valid=%b idx=%0d required %b/%b/%0d", s, grant2, gv2, gidx2, e, |e, idx_of(e));
            end
            $display("[TB] no_timeout step %0d grant=%b exp=%b", s, grant2, e);
        end
    endtask

    initial begin
        rst      = 1'b0;
        req      = '0;
        req2     = '0;
        flit_id  = '0;
        flit_id2 = '0;
        length   = '0;
        length2  = '0;
        test_reset();
        test_unlimited();
        test_budget_repeat();
        test_rotation();
        test_shrink();
        test_reset_mid_hold();
        test_no_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
